uio_port_arbiter: RTL and testbench



---
 rtl/uio_port_arbiter.sv | 134 +++++++++++++
 tb/tb_uio_port_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uio_port_arbiter.sv
// rtl/uio_port_arbiter.sv - round-robin owner arbitration of the shared uio pads with bus turnaround
// Optional: define UIO_ARB_LOCK_EN to add a per-requester lock input that suppresses hold-time preemption.
module uio_port_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int MAX_HOLD = 16,
   parameter int TURN_CYC = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ena,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ-1:0]     rel,
`ifdef UIO_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]     lock,
`endif
   input  logic [NUM_REQ*8-1:0]   req_out,
   input  logic [NUM_REQ*8-1:0]   req_oe,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   busy,
   input  logic [7:0]             uio_in,
   output logic [7:0]             rd_data,
   output logic [7:0]             uio_out,
   output logic [7:0]             uio_oe
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, TURN, OWN} state_t;

   state_t             state, state_nx;
   logic [IW-1:0]      ptr, winner, arb_idx, arb_start, ptr_after;
   logic [1:0]         turn_cnt;
   logic [7:0]         hold_cnt;
   logic               arb_found, own_exit, others_wait, hold_sat, preempt;
   logic [NUM_REQ-1:0] win_mask;
   logic [7:0]         sel_out, sel_oe;

   always_comb begin
      win_mask    = NUM_REQ'(1) << winner;
      others_wait = |(req & ~win_mask);
      hold_sat    = (hold_cnt == 8'(MAX_HOLD - 1));
`ifdef UIO_ARB_LOCK_EN
      preempt     = hold_sat && others_wait && !lock[winner];
`else
      preempt     = hold_sat && others_wait;
`endif
      own_exit    = rel[winner] || !req[winner] || !ena || preempt;
      ptr_after   = IW'((int'(winner) + 1) % NUM_REQ);
      sel_out     = req_out[{winner, 3'b000} +: 8];
      sel_oe      = req_oe[{winner, 3'b000} +: 8];
   end

   // On an OWN exit the next owner is chosen on the same edge, searching from the updated pointer.
   always_comb begin
      arb_start = (state == OWN) ? ptr_after : ptr;
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         logic [IW-1:0] idx;
         idx = IW'((int'(arb_start) + i) % NUM_REQ);
         if (!arb_found && req[idx]) begin
            arb_found = 1'b1;
            arb_idx   = idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (ena && arb_found) state_nx = TURN;
         TURN: begin
            if (!ena)                state_nx = IDLE;
            else if (turn_cnt == '0) state_nx = OWN;
         end
         OWN:  if (own_exit) state_nx = (ena && arb_found) ? TURN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      grant = (state == OWN) ? win_mask : '0;
      busy  = (state != IDLE);
   end

   // Pads only carry owner data while ownership continues past this edge; otherwise both are zeroed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         uio_out  <= '0;
         uio_oe   <= '0;
         ptr      <= '0;
         winner   <= '0;
         turn_cnt <= '0;
         hold_cnt <= '0;
      end else begin
         rd_data <= uio_in;
         uio_out <= '0;
         uio_oe  <= '0;
         case (state)
            IDLE: begin
               if (ena && arb_found) begin
                  winner   <= arb_idx;
                  turn_cnt <= 2'(TURN_CYC - 1);
               end
            end
            TURN: begin
               if (turn_cnt != '0) turn_cnt <= turn_cnt - 2'd1;
               hold_cnt <= '0;
            end
            OWN: begin
               if (own_exit) begin
                  ptr <= ptr_after;
                  if (ena && arb_found) begin
                     winner   <= arb_idx;
                     turn_cnt <= 2'(TURN_CYC - 1);
                  end
               end else begin
                  uio_out <= sel_out;
                  uio_oe  <= sel_oe;
                  if (!hold_sat) hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uio_port_arbiter.sv
// tb/tb_uio_port_arbiter.sv - directed self-checking bench for uio_port_arbiter (default parameters)
module tb_uio_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic [3:0]  req, rel;
`ifdef UIO_ARB_LOCK_EN
   logic [3:0]  lock;
`endif
   logic [31:0] req_out, req_oe;
   logic [3:0]  grant;
   logic        busy;
   logic [7:0]  uio_in, rd_data, uio_out, uio_oe;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   uio_port_arbiter dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .req     (req),
      .rel     (rel),
`ifdef UIO_ARB_LOCK_EN
      .lock    (lock),
`endif
      .req_out (req_out),
      .req_oe  (req_oe),
      .grant   (grant),
      .busy    (busy),
      .uio_in  (uio_in),
      .rd_data (rd_data),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      ena     = 1'b0;
      req     = 4'b0000;
      rel     = 4'b0000;
`ifdef UIO_ARB_LOCK_EN
      lock    = 4'b0000;
`endif
      req_out = {8'h44, 8'h33, 8'h22, 8'h11};
      req_oe  = {8'hF4, 8'hF3, 8'hF2, 8'hF1};
      uio_in  = 8'h00;
      tick();
      tick();
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      check("rst_uio_oe", uio_oe, 0);
      check("rst_uio_out", uio_out, 0);
      check("rst_rd_data", rd_data, 0);
      rst_n = 1'b1;
      uio_in = 8'h5A;
      tick();
      check("rd_data_reg", rd_data, 8'h5A);

      // Single requester, 1+TURN_CYC latency, pad latency, rel release
      ena = 1'b1;
      req = 4'b0001;
      tick();
      check("a_turn_grant", grant, 0);
      check("a_turn_busy", busy, 1);
      tick();
      check("a_grant", grant, 4'b0001);
      check("a_oe_first_own", uio_oe, 0);
      tick();
      check("a_oe", uio_oe, 8'hF1);
      check("a_out", uio_out, 8'h11);
      req_out[7:0] = 8'h99;
      tick();
      check("a_out_follow", uio_out, 8'h99);
      rel = 4'b0001;
      req = 4'b0000;
      tick();
      rel = 4'b0000;
      check("a_rel_grant", grant, 0);
      check("a_rel_oe", uio_oe, 0);
      check("a_rel_out", uio_out, 0);
      check("a_rel_busy", busy, 0);
      req_out[7:0] = 8'h11;

      // ena drop releases and holds off arbitration until ena returns
      req = 4'b0010;
      tick();
      tick();
      check("b_grant", grant, 4'b0010);
      tick();
      check("b_oe", uio_oe, 8'hF2);
      ena = 1'b0;
      tick();
      check("b_ena_grant", grant, 0);
      check("b_ena_oe", uio_oe, 0);
      check("b_ena_busy", busy, 0);
      tick();
      check("b_ena_idle", busy, 0);
      ena = 1'b1;
      tick();
      check("b_rearb_turn", busy, 1);
      check("b_rearb_turn_grant", grant, 0);
      tick();
      check("b_rearb_grant", grant, 4'b0010);
      req = 4'b0000;
      tick();
      check("b_drop_grant", grant, 0);

      // Async reset mid-OWN with oe=FF
      req_oe[31:24] = 8'hFF;
      req = 4'b1000;
      tick();
      tick();
      check("c_grant", grant, 4'b1000);
      tick();
      check("c_oe", uio_oe, 8'hFF);
      #2;
      rst_n = 1'b0;
      #1;
      check("c_async_oe", uio_oe, 0);
      check("c_async_grant", grant, 0);
      check("c_async_busy", busy, 0);
      req_oe[31:24] = 8'hF4;
      req = 4'b1111;
      tick();
      rst_n = 1'b1;
      tick();
      check("d_turn", grant, 0);
      tick();
      check("d_first_grant", grant, 4'b0001);

      // Full contention: each owner exactly MAX_HOLD cycles, one-cycle gap
      for (int r = 0; r < 5; r++) begin
         int o;
         o = r % 4;
         for (int c = 1; c < 16; c++) begin
            tick();
            check($sformatf("d_hold_o%0d_c%0d", o, c), grant, 32'(1) << o);
            if (c == 1) check($sformatf("d_oe_o%0d", o), uio_oe, 32'(8'hF1 + o));
         end
         tick();
         check($sformatf("d_gap_grant_o%0d", o), grant, 0);
         check($sformatf("d_gap_oe_o%0d", o), uio_oe, 0);
         tick();
         check($sformatf("d_next_o%0d", o), grant, 32'(1) << ((o + 1) % 4));
      end
      req = 4'b0000;
      tick();
      check("d_end_busy", busy, 0);

      // Uncontested owner keeps the bus; non-owner rel ignored
      req = 4'b0100;
      tick();
      tick();
      check("e_grant", grant, 4'b0100);
      for (int c = 0; c < 100; c++) begin
         if (c == 50) rel = 4'b0001;
         else         rel = 4'b0000;
         tick();
         check($sformatf("e_hold_c%0d", c), grant, 4'b0100);
      end

      // Saturated hold counter: a new contender preempts on the next edge
      req = 4'b0101;
      tick();
      check("f_preempt_grant", grant, 0);
      check("f_preempt_oe", uio_oe, 0);
      tick();
      check("f_new_owner", grant, 4'b0001);
      req = 4'b0000;
      tick();
      check("f_end_busy", busy, 0);

      // Winner drops req during TURN: one OWN cycle then release
      req = 4'b0010;
      tick();
      req = 4'b0000;
      check("g_turn", grant, 0);
      tick();
      check("g_own_one", grant, 4'b0010);
      tick();
      check("g_release", grant, 0);
      check("g_idle", busy, 0);

`ifdef UIO_ARB_LOCK_EN
      lock = 4'b0001;
      req  = 4'b0011;
      tick();
      tick();
      check("h_grant", grant, 4'b0001);
      for (int c = 0; c < 30; c++) begin
         tick();
         check($sformatf("h_lock_c%0d", c), grant, 4'b0001);
      end
      lock = 4'b0000;
      tick();
      check("h_unlock_gap", grant, 0);
      tick();
      check("h_handover", grant, 4'b0010);
      req = 4'b0000;
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
